mem_rd_stream: RTL and testbench
================================

// Module: mem_rd_stream
// PURPOSE
//  Read-side sequencer for the generic dual-port memory. Drives its combinational read
//  port over a programmed address range and presents the words as a valid/ready
//  stream to the downstream compute stage.
//  - One beat per cycle under continuous ready.
//  - Full backpressure support.
//  - Marks the final beat.
//  - Pulses done on completion.
// PARAMETERS
//  ADDRW  10  memory address width; range wraps modulo 2**ADDRW
//  DATAW   8  memory/stream data width
// PORTS
//  clk        in   1        single clock, all state on posedge
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        launch transfer; sampled only in IDLE
//  base_addr  in   ADDRW    first address, sampled with start
//  len        in   ADDRW+1  number of words, 0..2**ADDRW, sampled with start
//  busy       out  1        high from cycle after accepted start until done
//  done       out  1        one-cycle pulse after final beat accepted
//  rd_addr    out  ADDRW    to memory read address (registered)
//  rd_data    in   DATAW    from memory read data (combinational on rd_addr)
//  out_valid  out  1        stream beat valid
//  out_ready  in   1        downstream accepts beat when valid & ready
//  out_data   out  DATAW    stream data (registered)
//  out_last   out  1        qualifies the final beat of a transfer
// BEHAVIOUR
//  Reset values (async, rst=1): state=IDLE, busy=0, done=0, rd_addr=0, rem=0,
//  out_valid=0, out_data=0, out_last=0.
//  State IDLE (busy=0):
//  - start=1 & len!=0: rd_addr<=base_addr, rem<=len, goto RUN.
//  - start=1 & len==0: done<=1 next cycle, no beats, stay IDLE.
//  State RUN (busy=1):
//  - Load condition each cycle: load = !out_valid | out_ready.
//  - On load: out_data<=rd_data, out_valid<=1, out_last<=(rem==1),
//    rd_addr<=rd_addr+1 (mod 2**ADDRW), rem<=rem-1.
//  - If load & rem==1: goto LAST.
//  - If !load: all registers hold. out_data/out_last stay stable while valid & !ready.
//  State LAST (busy=1, final beat held):
//  - On out_ready: out_valid<=0, out_last<=0, done<=1, goto IDLE.
//  - busy falls in the same cycle done rises.
//  done: single-cycle pulse; deasserted in every other cycle.
//  start while busy: ignored, no effect on the running transfer.
//  Latency:
//  - start sampled at edge E0; rd_addr=base_addr after E0.
//  - First beat valid after E1.
//  - With ready held high: N beats on N consecutive cycles; done 1 cycle after last beat.
//  Wrap: base_addr+len > 2**ADDRW wraps to address 0. len=2**ADDRW reads every word once.
//  Widths: rem is ADDRW+1 bits; no other arithmetic beyond the address increment.
//  Memory coherence: a word is read in the cycle it is loaded. A same-cycle write to
//  that address is seen only if the memory write has already landed (read-before-write
//  at the edge).
//  Reset mid-transfer: all state returns to reset values immediately; no done pulse;
//  any beat in flight is dropped.
// TESTING
//  1. mem[i]=i; start, base=4, len=3, ready=1
//     -> beats 4,5,6 on consecutive cycles; last on 6; done 1 cycle later.
//  2. base=1022, len=4, ADDRW=10 -> rd_addr 1022,1023,0,1; data mem[1022],mem[1023],
//     mem[0],mem[1]; last on 4th beat.
//  3. len=5; ready toggles 1,0,0,1,... -> each beat held stable while ready=0;
//     exactly 5 handshakes; no duplicates or skips.
//  4. len=0 start -> done pulse next cycle; out_valid never asserts; busy stays 0.
//  5. start pulsed again during len=8 run -> ignored; exactly 8 beats, 1 done pulse.
//  6. rst asserted after 3rd beat of len=8 -> all outputs 0 asynchronously; no done;
//     a new start afterwards runs cleanly.

Source files
------------

// File: rtl/mem_rd_stream.sv
// Read-side sequencer: walks a memory read port over [base, base+len) and
// streams the words out over valid/ready, flagging the last beat.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   start, base_addr, len transfer request (sampled only when idle)
//   busy, done            transfer in progress / one-cycle completion pulse
//   rd_addr, rd_data      memory read port (data is combinational on addr)
//   out_valid, out_ready  stream handshake
//   out_data, out_last    stream payload and final-beat marker
module mem_rd_stream #(
  parameter int ADDRW = 10,
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   len,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] rd_addr,
  input  logic [DATAW-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_last
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] LAST = 2'd2;

  localparam logic [ADDRW:0]   REM_ONE = (ADDRW+1)'(1);
  localparam logic [ADDRW-1:0] ADR_ONE = ADDRW'(1);

  logic [1:0]     state;
  logic [ADDRW:0] rem;
  logic           load;
  logic           rem_is_one;

  // Output register is free, or its beat leaves this cycle.
  assign load       = !out_valid || out_ready;
  assign rem_is_one = (rem == REM_ONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      rd_addr   <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              rd_addr <= base_addr;
              rem     <= len;
              state   <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load) begin
            out_data  <= rd_data;
            out_valid <= 1'b1;
            out_last  <= rem_is_one;
            rd_addr   <= rd_addr + ADR_ONE;
            rem       <= rem - REM_ONE;
            if (rem_is_one) begin
              state <= LAST;
            end
          end
        end
        LAST: begin
          // Final beat is held here until taken.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_stream.sv
// Scoreboard bench for mem_rd_stream: stimulus queues expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_mem_rd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  logic [7:0]  mem [1024];
  logic [8:0]  q [$];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int rc = 0;

  mem_rd_stream #(.ADDRW(10), .DATAW(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .busy(busy),
    .done(done),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: mode 0 holds ready high, mode 1 runs 1,0,0,...
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else out_ready = (rc % 3 == 0);
    rc++;
  end

  // Monitor
  logic       hold_v = 1'b0;
  logic [8:0] hold_w = '0;
  logic       prev_done = 1'b0;
  logic       prev_last_hs = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      prev_done = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_stable", 32'({out_last, out_data}), 32'(hold_w));
      end
      if (prev_last_hs) begin
        chk("done_after_last", 32'(done), 32'd1);
        chk("busy_fall", 32'(busy), 32'd0);
      end else if (prev_done) begin
        chk("done_pulse_width", 32'(done), 32'd0);
      end
      if (done) done_cnt++;
      prev_done = done;
      prev_last_hs = 1'b0;
      hold_v = 1'b0;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none",
                   {out_last, out_data});
        end else begin
          chk("beat", 32'({out_last, out_data}), 32'(q.pop_front()));
        end
        prev_last_hs = out_last;
      end else if (out_valid) begin
        hold_v = 1'b1;
        hold_w = {out_last, out_data};
      end
    end
  end

  task automatic launch(input int b, input int l, input bit push);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b[9:0];
    len = l[10:0];
    if (push) begin
      for (int i = 0; i < l; i++) begin
        int a;
        a = (b + i) % 1024;
        q.push_back({(i == l - 1), a[7:0]});
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (l == 0) begin
      chk("zero_len_done", 32'(done), 32'd1);
      chk("zero_len_busy", 32'(busy), 32'd0);
    end else begin
      chk("start_addr", 32'(rd_addr), 32'(b));
      chk("start_busy", 32'(busy), 32'd1);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
    @(negedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
  endtask

  int h0;
  int d0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;

    @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic run
    launch(4, 3, 1'b1);
    wait_done("t1_done", 50);

    // Address wrap
    launch(1022, 4, 1'b1);
    wait_done("t2_done", 50);

    // Backpressure
    rdy_mode = 1;
    h0 = hs_cnt;
    launch(20, 5, 1'b1);
    wait_done("t3_done", 100);
    chk("t3_handshakes", 32'(hs_cnt - h0), 32'd5);
    rdy_mode = 0;

    // Zero length
    h0 = hs_cnt;
    d0 = done_cnt;
    launch(300, 0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("t4_no_valid", 32'(out_valid), 32'd0);
      chk("t4_no_busy", 32'(busy), 32'd0);
    end
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t4_no_beats", 32'(hs_cnt - h0), 32'd0);

    // Start while busy is ignored
    h0 = hs_cnt;
    d0 = done_cnt;
    launch(100, 8, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'd0;
    len = 11'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5_done", 50);
    repeat (3) @(negedge clk);
    chk("t5_handshakes", 32'(hs_cnt - h0), 32'd8);
    chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset mid-transfer
    h0 = hs_cnt;
    launch(200, 8, 1'b1);
    for (int i = 0; i < 50 && hs_cnt < h0 + 3; i++) @(negedge clk);
    chk("t6_three_beats", 32'(hs_cnt - h0 >= 3), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_last", 32'(out_last), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_addr", 32'(rd_addr), 32'd0);
    q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    rst = 1'b0;
    launch(50, 2, 1'b1);
    wait_done("t6_restart_done", 50);

    // Full-range transfer
    h0 = hs_cnt;
    launch(512, 1024, 1'b1);
    wait_done("t7_done", 1200);
    chk("t7_handshakes", 32'(hs_cnt - h0), 32'd1024);

    repeat (3) @(negedge clk);
    chk("done_total", 32'(done_cnt), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
